// File: rtl/axil_reg_bridge.sv
// rtl/axil_reg_bridge.sv - AXI4-Lite slave to single-outstanding register backend bridge; optional AXIL_BRIDGE_RANGE_CHECK_EN
module axil_reg_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int NUM_WORDS = 256,
    localparam int STRB_W   = DATA_W / 8,
    localparam int OFF_W    = $clog2(DATA_W / 8),
    localparam int IDX_W    = ADDR_W - OFF_W
) (
    input  logic              ACLK,
    input  logic              ARESETN,

    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,

    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,

    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,

    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,

    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,

    output logic              bk_req,
    output logic              bk_we,
    output logic [IDX_W-1:0]  bk_addr,
    output logic [DATA_W-1:0] bk_wdata,
    output logic [STRB_W-1:0] bk_wstrb,
    input  logic              bk_ack,
    input  logic [DATA_W-1:0] bk_rdata
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("axil_reg_bridge: DATA_W must be 32 or 64");
    end

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [IDX_W:0] NUM_WORDS_L = (IDX_W + 1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WR_CAP,
        WR_BK,
        WR_RESP,
        RD_BK,
        RD_RESP
    } state_t;

    state_t state, state_nxt;

    // rst_done holds the ready outputs low until the first clock after reset release
    logic              rst_done;
    logic              aw_cap;
    logic              w_cap;
    logic              rd_prio;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_have;
    logic              w_have;
    logic              wr_full;
    logic              rd_grant;
    logic              wr_grant;
    logic [IDX_W-1:0]  ar_idx;
    logic [IDX_W-1:0]  aw_idx_eff;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_oor;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^{AWADDR[OFF_W-1:0], ARADDR[OFF_W-1:0]};

    assign AWREADY = rst_done && (state == IDLE || state == WR_CAP) && !aw_cap;
    assign WREADY  = rst_done && (state == IDLE || state == WR_CAP) && !w_cap;

    assign aw_have = aw_cap | (AWVALID & AWREADY);
    assign w_have  = w_cap  | (WVALID  & WREADY);
    assign wr_full = aw_have & w_have;

    // AR is refused only when a complete write competes and the write side is owed the grant
    assign ARREADY  = rst_done && (state == IDLE) && !(wr_full && !rd_prio);
    assign rd_grant = ARVALID & ARREADY;
    assign wr_grant = wr_full && !rd_grant && (state == IDLE || state == WR_CAP);

    assign ar_idx     = ARADDR[ADDR_W-1:OFF_W];
    assign aw_idx_eff = aw_cap ? aw_idx_q : AWADDR[ADDR_W-1:OFF_W];
    assign grant_idx  = rd_grant ? ar_idx : aw_idx_eff;

`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
    assign grant_oor = ({1'b0, grant_idx} >= NUM_WORDS_L);
`else
    logic range_unused;
    assign range_unused = ^NUM_WORDS_L;
    assign grant_oor    = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_grant) begin
                    state_nxt = grant_oor ? RD_RESP : RD_BK;
                end else if (wr_full) begin
                    state_nxt = grant_oor ? WR_RESP : WR_BK;
                end else if (aw_have ^ w_have) begin
                    state_nxt = WR_CAP;
                end
            end
            WR_CAP: begin
                if (wr_full) begin
                    state_nxt = grant_oor ? WR_RESP : WR_BK;
                end
            end
            WR_BK: begin
                if (bk_ack) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    state_nxt = IDLE;
                end
            end
            RD_BK: begin
                if (bk_ack) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done <= 1'b0;
            aw_cap   <= 1'b0;
            w_cap    <= 1'b0;
            rd_prio  <= 1'b1;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bk_req   <= 1'b0;
            bk_we    <= 1'b0;
            bk_addr  <= '0;
            bk_wdata <= '0;
            bk_wstrb <= '0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            RVALID   <= 1'b0;
            RRESP    <= RESP_OKAY;
            RDATA    <= '0;
        end else begin
            rst_done <= 1'b1;

            if (AWVALID && AWREADY) begin
                aw_cap   <= 1'b1;
                aw_idx_q <= AWADDR[ADDR_W-1:OFF_W];
            end
            if (WVALID && WREADY) begin
                w_cap   <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end

            if (rd_grant) begin
                rd_prio <= 1'b0;
                bk_we   <= 1'b0;
                bk_addr <= ar_idx;
                bk_req  <= !grant_oor;
                if (grant_oor) begin
                    RVALID <= 1'b1;
                    RRESP  <= RESP_SLVERR;
                    RDATA  <= '0;
                end
            end

            // Later assignments to the capture flags override the capture above
            if (wr_grant) begin
                rd_prio  <= 1'b1;
                aw_cap   <= 1'b0;
                w_cap    <= 1'b0;
                bk_we    <= 1'b1;
                bk_addr  <= aw_idx_eff;
                bk_wdata <= w_cap ? wdata_q : WDATA;
                bk_wstrb <= w_cap ? wstrb_q : WSTRB;
                bk_req   <= !grant_oor;
                if (grant_oor) begin
                    BVALID <= 1'b1;
                    BRESP  <= RESP_SLVERR;
                end
            end

            if (state == WR_BK && bk_ack) begin
                bk_req <= 1'b0;
                BVALID <= 1'b1;
                BRESP  <= RESP_OKAY;
            end
            if (state == RD_BK && bk_ack) begin
                bk_req <= 1'b0;
                RVALID <= 1'b1;
                RRESP  <= RESP_OKAY;
                RDATA  <= bk_rdata;
            end

            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb/tb_axil_reg_bridge.sv - directed self-checking bench for axil_reg_bridge
module tb_axil_reg_bridge;

    logic        ACLK;
    logic        ARESETN;
    logic [15:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        bk_req;
    logic        bk_we;
    logic [13:0] bk_addr;
    logic [31:0] bk_wdata;
    logic [3:0]  bk_wstrb;
    logic        bk_ack;
    logic [31:0] bk_rdata;

    int errors = 0;
    int checks = 0;
    int req_cycles = 0;
    int req_base;

    axil_reg_bridge #(.DATA_W(32), .ADDR_W(16), .NUM_WORDS(256)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr),
        .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_ack(bk_ack), .bk_rdata(bk_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (bk_req === 1'b1) req_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        bk_ack = 1'b0; bk_rdata = '0;

        // reset state
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready",  64'(WREADY),  64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_bvalid",  64'(BVALID),  64'd0);
        chk("rst_rvalid",  64'(RVALID),  64'd0);
        chk("rst_bk_req",  64'(bk_req),  64'd0);
        chk("rst_rdata",   64'(RDATA),   64'd0);
        chk("rst_bk_addr", 64'(bk_addr), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", 64'(AWREADY), 64'd1);
        chk("rel_wready",  64'(WREADY),  64'd1);
        chk("rel_arready", 64'(ARREADY), 64'd1);

        // AW and W in the same cycle, ack in the first bk_req cycle
        AWADDR = 16'h0010; AWVALID = 1'b1;
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        #1;
        chk("w1_awready", 64'(AWREADY), 64'd1);
        chk("w1_wready",  64'(WREADY),  64'd1);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("w1_bk_req",   64'(bk_req),   64'd1);
        chk("w1_bk_addr",  64'(bk_addr),  64'd4);
        chk("w1_bk_we",    64'(bk_we),    64'd1);
        chk("w1_bk_wdata", 64'(bk_wdata), 64'hDEADBEEF);
        chk("w1_bk_wstrb", 64'(bk_wstrb), 64'hF);
        chk("w1_bvalid_early", 64'(BVALID), 64'd0);
        bk_ack = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("w1_bk_req_drop", 64'(bk_req), 64'd0);
        chk("w1_bvalid", 64'(BVALID), 64'd1);
        chk("w1_bresp",  64'(BRESP),  64'd0);
        @(negedge ACLK);
        chk("w1_bvalid_hold", 64'(BVALID), 64'd1);
        chk("w1_awready_busy", 64'(AWREADY), 64'd0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("w1_bvalid_done", 64'(BVALID), 64'd0);

        // W three cycles before AW, partial strobe
        req_base = req_cycles;
        WDATA = 32'hA5A5A5A5; WSTRB = 4'h5; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        #1;
        chk("w2_wait0_arready", 64'(ARREADY), 64'd0);
        chk("w2_wait0_wready",  64'(WREADY),  64'd0);
        chk("w2_wait0_awready", 64'(AWREADY), 64'd1);
        @(negedge ACLK);
        chk("w2_wait1_arready", 64'(ARREADY), 64'd0);
        chk("w2_wait1_bk_req",  64'(bk_req),  64'd0);
        @(negedge ACLK);
        AWADDR = 16'h0008; AWVALID = 1'b1;
        #1;
        chk("w2_aw_arready", 64'(ARREADY), 64'd0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("w2_bk_req",   64'(bk_req),   64'd1);
        chk("w2_bk_addr",  64'(bk_addr),  64'd2);
        chk("w2_bk_wstrb", 64'(bk_wstrb), 64'h5);
        chk("w2_bk_wdata", 64'(bk_wdata), 64'hA5A5A5A5);
        bk_ack = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("w2_bvalid", 64'(BVALID), 64'd1);
        chk("w2_req_count", 64'(req_cycles - req_base), 64'd1);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // zero strobe still reaches the backend
        AWADDR = 16'h000C; AWVALID = 1'b1;
        WDATA = 32'h0000FFFF; WSTRB = 4'h0; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("ws0_bk_req",   64'(bk_req),   64'd1);
        chk("ws0_bk_wstrb", 64'(bk_wstrb), 64'h0);
        chk("ws0_bk_addr",  64'(bk_addr),  64'd3);
        bk_ack = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b0;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // read with delayed ack and back-pressured R channel
        req_base = req_cycles;
        ARADDR = 16'h0020; ARVALID = 1'b1;
        #1;
        chk("r1_arready", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("r1_bk_addr", 64'(bk_addr), 64'd8);
        chk("r1_bk_we",   64'(bk_we),   64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("r1_bk_req_held", 64'(bk_req), 64'd1);
            @(negedge ACLK);
        end
        bk_ack = 1'b1; bk_rdata = 32'h12345678;
        @(negedge ACLK);
        bk_ack = 1'b0; bk_rdata = 32'hFFFFFFFF;
        chk("r1_req_count", 64'(req_cycles - req_base), 64'd5);
        chk("r1_bk_req_drop", 64'(bk_req), 64'd0);
        chk("r1_rvalid", 64'(RVALID), 64'd1);
        chk("r1_rresp",  64'(RRESP),  64'd0);
        chk("r1_rdata",  64'(RDATA),  64'h12345678);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            chk("r1_rvalid_hold", 64'(RVALID), 64'd1);
            chk("r1_rdata_hold",  64'(RDATA),  64'h12345678);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        chk("r1_rvalid_done", 64'(RVALID), 64'd0);

        // out-of-range index, unaligned address
        ARADDR = 16'h0402; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
        chk("oor_bk_req", 64'(bk_req), 64'd0);
        chk("oor_rvalid", 64'(RVALID), 64'd1);
        chk("oor_rresp",  64'(RRESP),  64'd2);
        chk("oor_rdata",  64'(RDATA),  64'd0);
`else
        chk("oor_bk_req",  64'(bk_req),  64'd1);
        chk("oor_bk_addr", 64'(bk_addr), 64'd256);
        bk_ack = 1'b1; bk_rdata = 32'h0BADF00D;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("oor_rvalid", 64'(RVALID), 64'd1);
        chk("oor_rresp",  64'(RRESP),  64'd0);
        chk("oor_rdata",  64'(RDATA),  64'h0BADF00D);
`endif
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;

        // reset while the backend read is pending, then a stray ack
        ARADDR = 16'h0030; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("mrst_bk_req_before", 64'(bk_req), 64'd1);
        ARESETN = 1'b0;
        #1;
        chk("mrst_bk_req",  64'(bk_req),  64'd0);
        chk("mrst_bk_addr", 64'(bk_addr), 64'd0);
        chk("mrst_arready", 64'(ARREADY), 64'd0);
        chk("mrst_rdata",   64'(RDATA),   64'd0);
        chk("mrst_rvalid",  64'(RVALID),  64'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b1; bk_rdata = 32'h00000077;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("mrst_late_rvalid", 64'(RVALID),  64'd0);
        chk("mrst_late_bk_req", 64'(bk_req),  64'd0);
        chk("mrst_arready_up",  64'(ARREADY), 64'd1);

        // contended arbitration: read, write, read
        ARADDR = 16'h0040; ARVALID = 1'b1;
        AWADDR = 16'h0080; AWVALID = 1'b1;
        WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1'b1;
        #1;
        chk("arb1_arready", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARADDR = 16'h0048;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("arb1_bk_we",   64'(bk_we),   64'd0);
        chk("arb1_bk_addr", 64'(bk_addr), 64'h10);
        bk_ack = 1'b1; bk_rdata = 32'hCAFE0001;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("arb1_rdata", 64'(RDATA), 64'hCAFE0001);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        #1;
        chk("arb2_arready", 64'(ARREADY), 64'd0);
        @(negedge ACLK);
        chk("arb2_bk_req",   64'(bk_req),   64'd1);
        chk("arb2_bk_we",    64'(bk_we),    64'd1);
        chk("arb2_bk_addr",  64'(bk_addr),  64'h20);
        chk("arb2_bk_wdata", 64'(bk_wdata), 64'h11111111);
        bk_ack = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("arb2_bvalid", 64'(BVALID), 64'd1);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        AWADDR = 16'h00C0; AWVALID = 1'b1;
        WDATA = 32'h22222222; WVALID = 1'b1;
        #1;
        chk("arb3_arready", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        chk("arb3_bk_we",   64'(bk_we),   64'd0);
        chk("arb3_bk_addr", 64'(bk_addr), 64'h12);
        bk_ack = 1'b1; bk_rdata = 32'hCAFE0002;
        @(negedge ACLK);
        bk_ack = 1'b0;
        chk("arb3_rdata", 64'(RDATA), 64'hCAFE0002);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("arb4_bk_we",    64'(bk_we),    64'd1);
        chk("arb4_bk_addr",  64'(bk_addr),  64'h30);
        chk("arb4_bk_wdata", 64'(bk_wdata), 64'h22222222);
        bk_ack = 1'b1;
        @(negedge ACLK);
        bk_ack = 1'b0;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("arb4_bvalid_done", 64'(BVALID), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 Parameter DATA_W, default 32, meaning AXI and backend data width; SHALL accept only 32 or 64.
REQ-002 Parameter ADDR_W, default 16, meaning AXI byte-address width.
REQ-003 Parameter NUM_WORDS, default 256, meaning backend words decoded when range checking is compiled in.
REQ-004 ACLK  input  1  clock; all logic SHALL be rising-edge.
REQ-005 ARESETN  input  1  reset, asynchronous, active-low.
REQ-006 AWADDR/AWVALID/AWREADY  in/in/out  ADDR_W/1/1  write-address channel.
REQ-007 WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write-data channel.
REQ-008 BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
REQ-009 ARADDR/ARVALID/ARREADY  in/in/out  ADDR_W/1/1  read-address channel.
REQ-010 RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_W/2/1/1  read-data channel.
REQ-011 bk_req/bk_we  output  1/1  backend request strobe, 1=write.
REQ-012 bk_addr  output  ADDR_W-log2(DATA_W/8)  backend word index, byte-offset bits dropped.
REQ-013 bk_wdata/bk_wstrb  output  DATA_W/DATA_W/8  backend write data and byte enables.
REQ-014 bk_ack/bk_rdata  input  1/DATA_W  backend completion and read data, valid with bk_ack.

Function
REQ-015 FSM states SHALL be IDLE, WR_CAP, WR_BK, WR_RESP, RD_BK, RD_RESP.
REQ-016 IDLE: AWREADY=WREADY=ARREADY=1 only in IDLE and only for channels not yet captured; each AW and W beat SHALL be captured independently, in either order or the same cycle.
REQ-017 WR_CAP: entered when exactly one of AW/W captured; SHALL wait for the other with ARREADY=0.
REQ-018 Arbitration: when AR and a complete write (AW+W) are both available in IDLE, grant SHALL alternate, the side not granted last time wins; after reset, read wins first.
REQ-019 WR_BK/RD_BK: bk_req SHALL be held 1 with bk_addr/bk_we/bk_wdata/bk_wstrb stable until the cycle bk_ack=1; bk_req SHALL deassert the cycle after.
REQ-020 Write-strobe passthrough: bk_wstrb SHALL equal captured WSTRB; WSTRB=0 SHALL still issue a backend write.
REQ-021 RD_BK->RD_RESP: RDATA SHALL register bk_rdata on bk_ack; RVALID=1, RRESP=2'b00 next cycle, held until RREADY=1.
REQ-022 WR_BK->WR_RESP: BVALID=1, BRESP=2'b00 the cycle after bk_ack, held until BREADY=1.
REQ-023 Minimum latency: handshake to VALID SHALL be 2 cycles with bk_ack returned in the first bk_req cycle.
REQ-024 Exactly one transaction SHALL be outstanding; no new AR/AW/W accepted until the B or R handshake completes and FSM returns to IDLE.
REQ-025 VALID/data outputs SHALL not change while VALID=1 and READY=0.
REQ-026 Address byte-offset bits SHALL be ignored (unaligned accesses treated as aligned).

Reset
REQ-027 ARESETN low SHALL immediately force IDLE, AWREADY=WREADY=ARREADY=0 (asserted first cycle after release), BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, bk_req=0, bk_we=0, bk_addr/bk_wdata/bk_wstrb=0, capture flags cleared, arbitration to read-first.
REQ-028 Reset mid-transaction SHALL abandon it with no response; a bk_ack after reset SHALL be ignored.

Configuration
REQ-029 Macro AXIL_BRIDGE_RANGE_CHECK_EN defined: word index >= NUM_WORDS SHALL skip the backend (no bk_req) and respond from WR_RESP/RD_RESP next cycle with BRESP/RRESP=2'b10 (SLVERR), RDATA=0.
REQ-030 Macro undefined: all addresses SHALL be forwarded, responses always 2'b00, NUM_WORDS unused.

Verification
REQ-031 AW 0x0010 and W 0xDEADBEEF/WSTRB 0xF same cycle, bk_ack in 1st cycle -> bk_addr=4, bk_we=1, BVALID 2 cycles later, BRESP=00.
REQ-032 W beat 3 cycles before AW 0x0008, WSTRB 0x5 -> ARREADY=0 during wait, bk_wstrb=0x5, bk_addr=2, single bk_req.
REQ-033 AR 0x0020, bk_ack delayed 4 cycles with bk_rdata 0x12345678, RREADY low 2 cycles -> bk_req held 5 cycles, RDATA=0x12345678 stable until RREADY.
REQ-034 AR and AW+W pending simultaneously, three times back-to-back -> order read, write, read.
REQ-035 With AXIL_BRIDGE_RANGE_CHECK_EN, NUM_WORDS=256, AR 0x0400 -> no bk_req, RRESP=10, RDATA=0; without macro -> bk_addr=256, RRESP=00.
REQ-036 ARESETN low while bk_req=1 in RD_BK -> all outputs reset values; late bk_ack produces no RVALID.
